// File: rtl/card_deal_sequencer.sv
// Card deal sequencer: runs the initial player/dealer deal and arbitrates
// single-card requests. Between draws it waits a settle interval so the free-running
// RNG advances, and it rejects card samples that are not valid card values.
module card_deal_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_REJECTS   = 16
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] card_value,
    input  logic       start_deal,
    input  logic       p_req,
    input  logic       d_req,
    output logic       p_gnt,
    output logic       d_gnt,
    output logic [3:0] card_out,
    output logic       deal_busy,
    output logic       deal_done,
    output logic [5:0] draw_count,
    output logic       rng_fault
);

    localparam int RW = (MAX_REJECTS < 2) ? 1 : $clog2(MAX_REJECTS);
    localparam logic [7:0]    GAP_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] REJ_LAST = RW'(MAX_REJECTS - 1);

    typedef enum logic [2:0] {IDLE, DEAL_GAP, DEAL_DRAW, GAP, DRAW} state_t;

    state_t        state, state_nx;
    logic [7:0]    gap_cnt, gap_nx;
    logic [RW-1:0] rej_cnt, rej_nx;
    logic [1:0]    deal_idx, idx_nx;
    logic          tgt_p, tgt_nx;
    logic          rr_last_p, rr_nx;
    logic          p_gnt_nx, d_gnt_nx, busy_nx, done_nx, fault_nx;
    logic [3:0]    card_nx;
    logic [5:0]    cnt_nx;
    logic          req_held, valid, sampling, issue, issue_p;
    logic [3:0]    issue_val;

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_nx  = state;
        gap_nx    = gap_cnt;
        rej_nx    = rej_cnt;
        idx_nx    = deal_idx;
        tgt_nx    = tgt_p;
        rr_nx     = rr_last_p;
        p_gnt_nx  = 1'b0;
        d_gnt_nx  = 1'b0;
        done_nx   = 1'b0;
        busy_nx   = deal_busy;
        card_nx   = card_out;
        cnt_nx    = draw_count;
        fault_nx  = rng_fault;
        issue     = 1'b0;
        issue_p   = 1'b0;
        issue_val = card_value;

        req_held = tgt_p ? p_req : d_req;
        valid    = (card_value >= 4'd1) && (card_value <= 4'd10);
        sampling = (state == DEAL_DRAW) || ((state == DRAW) && req_held);

        if (sampling) begin
            if (valid) begin
                issue = 1'b1;
            end else if (rej_cnt == REJ_LAST) begin
                issue     = 1'b1;
                issue_val = 4'd10;
                fault_nx  = 1'b1;
            end else begin
                rej_nx = rej_cnt + RW'(1);
            end
        end

        case (state)
            IDLE: begin
                busy_nx = 1'b0;
                gap_nx  = 8'd0;
                if (start_deal) begin
                    busy_nx  = 1'b1;
                    cnt_nx   = 6'd0;
                    idx_nx   = 2'd0;
                    state_nx = DEAL_GAP;
                end else if (p_req || d_req) begin
                    tgt_nx   = (p_req && d_req) ? ~rr_last_p : p_req;
                    state_nx = GAP;
                end
            end
            DEAL_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_nx   = 8'd0;
                    rej_nx   = '0;
                    state_nx = DEAL_DRAW;
                end else begin
                    gap_nx = gap_cnt + 8'd1;
                end
            end
            GAP: begin
                if (!req_held) begin
                    gap_nx   = 8'd0;
                    state_nx = IDLE;
                end else if (gap_cnt == GAP_LAST) begin
                    gap_nx   = 8'd0;
                    rej_nx   = '0;
                    state_nx = DRAW;
                end else begin
                    gap_nx = gap_cnt + 8'd1;
                end
            end
            DEAL_DRAW: begin
                issue_p = ~deal_idx[0];
                if (issue) begin
                    if (deal_idx == 2'd3) begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        idx_nx   = deal_idx + 2'd1;
                        state_nx = DEAL_GAP;
                    end
                end
            end
            DRAW: begin
                issue_p = tgt_p;
                if (!req_held) begin
                    state_nx = IDLE;
                end else if (issue) begin
                    rr_nx    = tgt_p;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (issue) begin
            card_nx  = issue_val;
            rej_nx   = '0;
            p_gnt_nx = issue_p;
            d_gnt_nx = ~issue_p;
            cnt_nx   = (draw_count == 6'd52) ? 6'd52 : draw_count + 6'd1;
        end
    end

    // State and output registers with synchronous reset; the player wins the first tie.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            gap_cnt    <= 8'd0;
            rej_cnt    <= '0;
            deal_idx   <= 2'd0;
            tgt_p      <= 1'b0;
            rr_last_p  <= 1'b0;
            p_gnt      <= 1'b0;
            d_gnt      <= 1'b0;
            card_out   <= 4'd0;
            deal_busy  <= 1'b0;
            deal_done  <= 1'b0;
            draw_count <= 6'd0;
            rng_fault  <= 1'b0;
        end else begin
            state      <= state_nx;
            gap_cnt    <= gap_nx;
            rej_cnt    <= rej_nx;
            deal_idx   <= idx_nx;
            tgt_p      <= tgt_nx;
            rr_last_p  <= rr_nx;
            p_gnt      <= p_gnt_nx;
            d_gnt      <= d_gnt_nx;
            card_out   <= card_nx;
            deal_busy  <= busy_nx;
            deal_done  <= done_nx;
            draw_count <= cnt_nx;
            rng_fault  <= fault_nx;
        end
    end

endmodule

// File: tb/tb_card_deal_sequencer.sv
// Testbench for card_deal_sequencer: directed vector table, hand-written corner
// sequences and randomized traffic checked against a transaction-level model.
module tb_card_deal_sequencer;

    localparam int SETTLE = 4;
    localparam int MAXREJ = 16;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] card_value = 4'd0;
    logic       start_deal = 1'b0;
    logic       p_req = 1'b0;
    logic       d_req = 1'b0;
    logic       p_gnt, d_gnt, deal_busy, deal_done, rng_fault;
    logic [3:0] card_out;
    logic [5:0] draw_count;

    card_deal_sequencer #(.SETTLE_CYCLES(SETTLE), .MAX_REJECTS(MAXREJ)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .card_value(card_value),
        .start_deal(start_deal), .p_req(p_req), .d_req(d_req),
        .p_gnt(p_gnt), .d_gnt(d_gnt), .card_out(card_out),
        .deal_busy(deal_busy), .deal_done(deal_done),
        .draw_count(draw_count), .rng_fault(rng_fault)
    );

    // 50 MHz-style free-running clock.
    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int passes = 0;
    int cycle  = 0;

    // Reference model: mode 0 idle, 1 dealing, 2 serving one request.
    int   m_mode = 0, m_wait = 0, m_dealt = 0, m_rej = 0;
    bit   m_who = 0, m_last = 0;
    bit   e_pg = 0, e_dg = 0, e_busy = 0, e_done = 0, e_fault = 0;
    logic [3:0] e_card = 4'd0;
    int   e_cnt = 0;

    typedef struct {
        bit rst; bit start; bit preq; bit dreq; logic [3:0] card; int reps;
        bit pg; bit dg; logic [3:0] cout; bit busy; bit done; logic [5:0] cnt; bit fault;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [14:0] dutVec();
        return {p_gnt, d_gnt, card_out, deal_busy, deal_done, draw_count, rng_fault};
    endfunction

    function automatic logic [14:0] modelVec();
        return {e_pg, e_dg, e_card, e_busy, e_done, 6'(e_cnt), e_fault};
    endfunction

    task automatic modelStep(input bit r, input bit s, input bit p, input bit d, input logic [3:0] c);
        bit give;
        bit to_p;
        logic [3:0] val;
        e_pg = 0; e_dg = 0; e_done = 0;
        if (r) begin
            e_busy = 0; e_fault = 0; e_card = 0; e_cnt = 0;
            m_mode = 0; m_last = 0; m_wait = 0; m_dealt = 0; m_rej = 0;
            return;
        end
        if (m_mode == 0) begin
            if (s) begin
                m_mode = 1; m_dealt = 0; e_cnt = 0; e_busy = 1; m_wait = SETTLE; m_rej = 0;
            end else begin
                e_busy = 0;
                if (p || d) begin
                    m_mode = 2; m_who = (p && d) ? !m_last : p; m_wait = SETTLE; m_rej = 0;
                end
            end
            return;
        end
        if (m_mode == 2 && !(m_who ? p : d)) begin
            m_mode = 0;
            return;
        end
        if (m_wait > 0) begin
            m_wait--;
            return;
        end
        give = 0; val = c; to_p = 0;
        if (c >= 1 && c <= 10) give = 1;
        else if (m_rej + 1 >= MAXREJ) begin give = 1; val = 4'd10; e_fault = 1; end
        else m_rej++;
        if (!give) return;
        m_rej = 0;
        e_card = val;
        if (e_cnt < 52) e_cnt++;
        if (m_mode == 1) begin
            to_p = (m_dealt % 2 == 0);
            m_dealt++;
            if (m_dealt == 4) begin e_done = 1; m_mode = 0; end
            else m_wait = SETTLE;
        end else begin
            to_p = m_who; m_last = m_who; m_mode = 0;
        end
        if (to_p) e_pg = 1; else e_dg = 1;
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit p, input bit d, input logic [3:0] c);
        reset = r; start_deal = s; p_req = p; d_req = d; card_value = c;
        @(posedge CLOCK_50);
        modelStep(r, s, p, d, c);
        #1;
        cycle++;
    endtask

    task automatic checkOutput(input string name, input logic [14:0] exp);
        logic [14:0] got;
        got = dutVec();
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s @cycle %0d: got pg=%0d dg=%0d card=%0d busy=%0d done=%0d cnt=%0d fault=%0d, expected pg=%0d dg=%0d card=%0d busy=%0d done=%0d cnt=%0d fault=%0d",
                      name, cycle, got[14], got[13], got[12:9], got[8], got[7], got[6:1], got[0],
                      exp[14], exp[13], exp[12:9], exp[8], exp[7], exp[6:1], exp[0]);
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("[TB] FAIL %s @cycle %0d: got %0d, expected %0d", name, cycle, got, exp);
    endtask

    task automatic tick(input bit r, input bit s, input bit p, input bit d, input logic [3:0] c);
        applyStimulus(r, s, p, d, c);
        checkOutput("model", modelVec());
    endtask

    bit rp = 0, rd = 0;

    // Test sequence: vector table, directed corner cases, then random traffic.
    initial begin
        int gedge, dedge, redge, base, gcount;
        // Initial deal with card 7, then tie-breaking requests with card 3.
        tbl.push_back('{1,0,0,0,4'd7,2, 0,0,4'd0,0,0,6'd0,0});
        tbl.push_back('{0,1,0,0,4'd7,1, 0,0,4'd0,1,0,6'd0,0});
        tbl.push_back('{0,0,0,0,4'd7,4, 0,0,4'd0,1,0,6'd0,0});
        tbl.push_back('{0,0,0,0,4'd7,1, 1,0,4'd7,1,0,6'd1,0});
        tbl.push_back('{0,0,0,0,4'd7,4, 0,0,4'd7,1,0,6'd1,0});
        tbl.push_back('{0,0,0,0,4'd7,1, 0,1,4'd7,1,0,6'd2,0});
        tbl.push_back('{0,0,0,0,4'd7,4, 0,0,4'd7,1,0,6'd2,0});
        tbl.push_back('{0,0,0,0,4'd7,1, 1,0,4'd7,1,0,6'd3,0});
        tbl.push_back('{0,0,0,0,4'd7,4, 0,0,4'd7,1,0,6'd3,0});
        tbl.push_back('{0,0,0,0,4'd7,1, 0,1,4'd7,1,1,6'd4,0});
        tbl.push_back('{0,0,0,0,4'd7,1, 0,0,4'd7,0,0,6'd4,0});
        tbl.push_back('{1,0,0,0,4'd3,2, 0,0,4'd0,0,0,6'd0,0});
        tbl.push_back('{0,0,1,1,4'd3,5, 0,0,4'd0,0,0,6'd0,0});
        tbl.push_back('{0,0,1,1,4'd3,1, 1,0,4'd3,0,0,6'd1,0});
        tbl.push_back('{0,0,1,1,4'd3,5, 0,0,4'd3,0,0,6'd1,0});
        tbl.push_back('{0,0,1,1,4'd3,1, 0,1,4'd3,0,0,6'd2,0});
        tbl.push_back('{0,0,0,0,4'd3,1, 0,0,4'd3,0,0,6'd2,0});
        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].reps; k++) begin
                applyStimulus(tbl[i].rst, tbl[i].start, tbl[i].preq, tbl[i].dreq, tbl[i].card);
                checkOutput($sformatf("table row %0d", i),
                            {tbl[i].pg, tbl[i].dg, tbl[i].cout, tbl[i].busy, tbl[i].done, tbl[i].cnt, tbl[i].fault});
            end
        end

        // Three rejected samples delay the grant by three cycles.
        tick(1,0,0,0,0); tick(1,0,0,0,0);
        gedge = -1;
        for (int k = 0; k < 30 && gedge < 0; k++) begin
            tick(0, 0, 1, 0, (k >= SETTLE + 1 && k <= SETTLE + 3) ? 4'd0 : 4'd9);
            if (p_gnt) gedge = k;
        end
        checkValue("reject grant edge", gedge, SETTLE + 4);
        checkValue("reject card", card_out, 9);
        checkValue("reject no fault", rng_fault, 0);
        tick(0,0,0,0,9);

        // Stuck invalid RNG forces a fault grant of 10 and a sticky flag.
        tick(1,0,0,0,0);
        gedge = -1;
        for (int k = 0; k < 40 && gedge < 0; k++) begin
            tick(0, 0, 1, 0, 4'd15);
            if (p_gnt) gedge = k;
        end
        checkValue("fault grant edge", gedge, SETTLE + MAXREJ);
        checkValue("fault card", card_out, 10);
        checkValue("fault flag", rng_fault, 1);
        for (int k = 0; k < 5; k++) tick(0,0,0,0,4'd15);
        checkValue("fault sticky", rng_fault, 1);
        tick(1,0,0,0,0);
        checkValue("fault cleared by reset", rng_fault, 0);

        // Requester withdraws during the gap: no grant, count unchanged.
        base = draw_count; gcount = 0;
        for (int k = 0; k < 3; k++) begin tick(0,0,1,0,5); gcount += p_gnt + d_gnt; end
        for (int k = 0; k < 8; k++) begin tick(0,0,0,0,5); gcount += p_gnt + d_gnt; end
        checkValue("withdraw no grant", gcount, 0);
        checkValue("withdraw count", draw_count, base);

        // start_deal beats d_req; d_req waits until the deal completes.
        tick(0,1,0,1,6);
        dedge = -1; redge = -1;
        for (int k = 1; k < 80 && redge < 0; k++) begin
            tick(0,0,0,1,6);
            if (deal_done) dedge = k;
            else if (d_gnt && dedge >= 0) redge = k;
        end
        checkValue("deal done edge", dedge, 4 * (SETTLE + 1));
        checkValue("held d_req grant delay", redge - dedge, SETTLE + 2);
        checkValue("count after deal+req", draw_count, 5);
        tick(0,0,0,0,6);

        // Reset on the edge of the second deal grant cancels everything.
        tick(1,0,0,0,7);
        tick(0,1,0,0,7);
        for (int k = 1; k < 2 * (SETTLE + 1); k++) tick(0,0,0,0,7);
        tick(1,0,0,0,7);
        checkOutput("reset mid-deal", 15'd0);
        gcount = 0;
        for (int k = 0; k < 15; k++) begin tick(0,0,0,0,7); gcount += p_gnt + d_gnt; end
        checkValue("no grants after reset", gcount, 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) rp = !rp;
            if ($urandom_range(0, 7) == 0) rd = !rd;
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, rp, rd,
                 4'($urandom_range(0, 15)));
            if (p_gnt && d_gnt) checkValue("grant exclusive", 1, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/card_deal_sequencer.md
CARD_DEAL_SEQUENCER -- requirements
Module: card_deal_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4, range 1..255: idle cycles between consecutive card draws so the RNG advances.
REQ-002 The block SHALL have parameter MAX_REJECTS, default 16: consecutive invalid RNG samples tolerated before the fault path is taken.
REQ-003 The block SHALL have port CLOCK_50  input  1  system clock; the only clock.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port card_value  input  4  free-running card from card_rng.
REQ-006 The block SHALL have port start_deal  input  1  single-cycle pulse requesting the initial 4-card deal.
REQ-007 The block SHALL have port p_req  input  1  player card request, level, held until grant.
REQ-008 The block SHALL have port d_req  input  1  dealer card request, level, held until grant.
REQ-009 The block SHALL have port p_gnt  output  1  single-cycle pulse; card_out is the player's card.
REQ-010 The block SHALL have port d_gnt  output  1  single-cycle pulse; card_out is the dealer's card.
REQ-011 The block SHALL have port card_out  output  4  issued card value, held until the next grant.
REQ-012 The block SHALL have port deal_busy  output  1  high while the initial deal is in progress.
REQ-013 The block SHALL have port deal_done  output  1  single-cycle pulse coincident with the 4th deal grant.
REQ-014 The block SHALL have port draw_count  output  6  cards issued since the last accepted start_deal.
REQ-015 The block SHALL have port rng_fault  output  1  sticky flag; MAX_REJECTS consecutive invalid samples seen.

Function
REQ-016 The block SHALL implement FSM states IDLE, DEAL_GAP, DEAL_DRAW, GAP, DRAW; all outputs SHALL be registered.
REQ-017 In IDLE, a sampled start_deal SHALL win over any request: clear draw_count and deal index, assert deal_busy, go to DEAL_GAP.
REQ-018 In IDLE with no start_deal, a request SHALL be latched, go to GAP; if p_req and d_req are both high, round-robin SHALL pick the requester not granted last.
REQ-019 The round-robin pointer SHALL update only on request-mode grants; deal grants SHALL NOT change it.
REQ-020 GAP and DEAL_GAP SHALL each last exactly SETTLE_CYCLES cycles, then enter DRAW or DEAL_DRAW respectively.
REQ-021 DRAW/DEAL_DRAW SHALL sample card_value each cycle; values 1..10 are valid; 0 and 11..15 SHALL be rejected and resampled the next cycle.
REQ-022 On a valid sample, the block SHALL load card_out, pulse the target grant, and increment draw_count, saturating at 52.
REQ-023 With no rejects, the grant SHALL assert SETTLE_CYCLES+1 clock edges after the edge that accepted the request or start_deal, or the previous deal grant.
REQ-024 The deal order SHALL be player, dealer, player, dealer.
REQ-025 After the 4th deal grant, the block SHALL pulse deal_done in the same cycle, deassert deal_busy on the next edge, and return to IDLE.
REQ-026 After a request-mode grant, the FSM SHALL return to IDLE; a held request SHALL be re-arbitrated no earlier than the following edge.
REQ-027 If the latched requester deasserts during GAP or DRAW, the block SHALL return to IDLE with no grant and no draw_count change.
REQ-028 p_req and d_req SHALL be ignored during deal states; they SHALL NOT be granted until IDLE is re-entered.
REQ-029 start_deal SHALL be ignored in every state except IDLE.
REQ-030 The reject counter SHALL clear on each entry to DRAW/DEAL_DRAW and on each valid sample.
REQ-031 On reaching MAX_REJECTS consecutive rejects, the block SHALL set rng_fault, issue card_out=10 as a normal grant, and continue.
REQ-032 p_gnt and d_gnt SHALL never be high in the same cycle.

Reset
REQ-033 Reset SHALL apply on any edge, in any state including mid-deal, and return the FSM to IDLE.
REQ-034 Reset SHALL drive outputs to: p_gnt=0, d_gnt=0, card_out=0, deal_busy=0, deal_done=0, draw_count=0, rng_fault=0.
REQ-035 Reset SHALL clear the gap and reject counters and the deal index, and set the round-robin pointer so the player wins the first tie.
REQ-036 A grant pending at the reset edge SHALL NOT be issued.

Verification (SETTLE_CYCLES=4)
REQ-037 start_deal pulse, card_value held 7 -> grants P,D,P,D at edges 5,10,15,20; deal_done with 4th; draw_count=4; deal_busy low at edge 21.
REQ-038 p_req and d_req high together from reset, card 3 -> p_gnt at edge 5, then d_gnt at edge 11; never simultaneous.
REQ-039 p_req high, card_value=0 for 3 cycles then 9 -> p_gnt 3 cycles late, card_out=9, rng_fault=0.
REQ-040 card_value stuck at 15, p_req high -> after 16 rejects p_gnt with card_out=10, rng_fault=1 until reset.
REQ-041 p_req dropped during GAP -> no grant, draw_count unchanged; start_deal and d_req same cycle in IDLE -> deal runs, d_req granted only after deal_done.
REQ-042 reset asserted at the 2nd deal grant -> next cycle all outputs zero, FSM in IDLE, no further grants.
